// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 pixel capture path.
package ov7670_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned RGB_R_W = 5;
  localparam int unsigned RGB_G_W = 6;
  localparam int unsigned RGB_B_W = 5;
  localparam int unsigned PIX_W   = RGB_R_W + RGB_G_W + RGB_B_W;

  typedef enum logic [1:0] {
    StSync,
    StFrame,
    StLine,
    StCapt
  } cap_state_e;

endpackage

// File: rtl/ov7670_pixel_capture_if.sv
// Camera byte stream in, frame-buffer write port out.
interface ov7670_pixel_capture_if #(
  parameter int unsigned ADDR_W = 19
) ();

  logic [ov7670_pkg::BYTE_W-1:0] din;
  logic                          vsync;
  logic                          href;
  logic [ov7670_pkg::PIX_W-1:0]  pix_data;
  logic [ADDR_W-1:0]             pix_addr;
  logic                          pix_we;
  logic                          frame_done;
  logic                          line_err;

  modport master (
    output din, vsync, href,
    input  pix_data, pix_addr, pix_we, frame_done, line_err
  );

  modport slave (
    input  din, vsync, href,
    output pix_data, pix_addr, pix_we, frame_done, line_err
  );

endinterface

// File: rtl/ov7670_edge_det.sv
// Registered rise/fall detector; edges are flagged in the cycle the new level is sampled.
module ov7670_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/ov7670_pixel_capture.sv
// OV7670 byte-pair to RGB565 frame-buffer writer, pclk domain only.
// Define OV7670_DECIM2_EN for 2:1 decimation in both axes.
module ov7670_pixel_capture
  import ov7670_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic                   pclk,
  input  logic                   reset,
  ov7670_pixel_capture_if.slave  bus
);

  localparam int unsigned XW = $clog2(H_ACTIVE + 1);
  localparam int unsigned YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0] XEnd  = XW'(H_ACTIVE);
  localparam logic [YW-1:0] YEnd  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] YLast = YW'(V_ACTIVE - 1);

  cap_state_e        state_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic              phase_q;
  logic              ovf_q;
  logic [BYTE_W-1:0] hi_q;
  logic [ADDR_W-1:0] base_q;

  logic vs_rise, vs_fall, hr_rise, hr_fall;
  logic unused_edges;
  logic wr_ok, step_base;
  logic [ADDR_W-1:0] addr_x;

  ov7670_edge_det u_vs_edge (
    .clk_i  (pclk),
    .rst_ni (reset),
    .sig_i  (bus.vsync),
    .rise_o (vs_rise),
    .fall_o (vs_fall)
  );

  ov7670_edge_det u_hr_edge (
    .clk_i  (pclk),
    .rst_ni (reset),
    .sig_i  (bus.href),
    .rise_o (hr_rise),
    .fall_o (hr_fall)
  );

  assign unused_edges = vs_fall ^ hr_rise;

`ifdef OV7670_DECIM2_EN
  localparam logic [ADDR_W-1:0] LineStep = ADDR_W'(H_ACTIVE / 2);
  assign wr_ok     = (x_q < XEnd) && (y_q < YEnd) && !x_q[0] && !y_q[0];
  assign addr_x    = ADDR_W'(x_q >> 1);
  // Stored rows advance only after each odd source line.
  assign step_base = y_q[0] && (y_q < YLast);
`else
  localparam logic [ADDR_W-1:0] LineStep = ADDR_W'(H_ACTIVE);
  assign wr_ok     = (x_q < XEnd) && (y_q < YEnd);
  assign addr_x    = ADDR_W'(x_q);
  assign step_base = (y_q < YLast);
`endif

  always_ff @(posedge pclk) begin
    if (!reset) begin
      state_q        <= StSync;
      x_q            <= '0;
      y_q            <= '0;
      phase_q        <= 1'b0;
      ovf_q          <= 1'b0;
      hi_q           <= '0;
      base_q         <= '0;
      bus.pix_data   <= '0;
      bus.pix_addr   <= '0;
      bus.pix_we     <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.line_err   <= 1'b0;
    end else begin
      bus.pix_we     <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.line_err   <= 1'b0;
      unique case (state_q)
        StSync: begin
          if (vs_rise) state_q <= StFrame;
        end
        StFrame: begin
          x_q     <= '0;
          y_q     <= '0;
          phase_q <= 1'b0;
          ovf_q   <= 1'b0;
          base_q  <= '0;
          if (!bus.vsync) state_q <= StLine;
        end
        StLine: begin
          if (vs_rise) begin
            state_q        <= StFrame;
            bus.frame_done <= 1'b1;
          end else if (bus.href) begin
            hi_q    <= bus.din;
            phase_q <= 1'b1;
            state_q <= StCapt;
          end
        end
        StCapt: begin
          if (vs_rise) begin
            // Any half-assembled pixel is simply abandoned.
            state_q        <= StFrame;
            bus.frame_done <= 1'b1;
          end else if (bus.href) begin
            if (!phase_q) begin
              hi_q    <= bus.din;
              phase_q <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              if (wr_ok) begin
                bus.pix_data <= {hi_q, bus.din};
                bus.pix_addr <= base_q + addr_x;
                bus.pix_we   <= 1'b1;
              end
              if (x_q == XEnd) ovf_q <= 1'b1;
              else             x_q   <= x_q + 1'b1;
            end
          end else if (hr_fall) begin
            state_q      <= StLine;
            bus.line_err <= (x_q != XEnd) | phase_q | ovf_q;
            x_q          <= '0;
            phase_q      <= 1'b0;
            ovf_q        <= 1'b0;
            if (y_q != YEnd) y_q <= y_q + 1'b1;
            if (step_base) base_q <= base_q + LineStep;
          end
        end
        default: state_q <= StSync;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Scoreboard bench for ov7670_pixel_capture with a line-level reference model.
module tb_ov7670_pixel_capture;

  localparam int unsigned H  = 4;
  localparam int unsigned V  = 2;
  localparam int unsigned AW = 3;

  typedef logic [7:0] byteq_t[$];
  typedef struct {
    logic [15:0]   data;
    logic [AW-1:0] addr;
  } wr_t;

  logic pclk  = 1'b0;
  logic reset = 1'b0;
  always #5 pclk = ~pclk;

  ov7670_pixel_capture_if #(.ADDR_W(AW)) bus ();

  ov7670_pixel_capture #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .ADDR_W   (AW)
  ) dut (
    .pclk  (pclk),
    .reset (reset),
    .bus   (bus)
  );

  wr_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  exp_fd = 0, exp_le = 0, got_fd = 0, got_le = 0;
  bit  frame_open = 1'b0;
  int  y_m = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(posedge pclk);
      #1;
      if (reset) begin
        if (bus.pix_we) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write: got data %h addr %0d, expected no write",
                     bus.pix_data, bus.pix_addr);
          end else begin
            e = exp_q.pop_front();
            if (bus.pix_data !== e.data || bus.pix_addr !== e.addr) begin
              miscompares++;
              $display("FAIL write: got data %h addr %0d, expected data %h addr %0d",
                       bus.pix_data, bus.pix_addr, e.data, e.addr);
            end
          end
        end
        if (bus.frame_done) got_fd++;
        if (bus.line_err) got_le++;
      end
    end
  end

  // Reference model: pixels of one line, written straight from the frame rules.
  function automatic void model_line(input byteq_t b, input bit complete);
    int  np;
    int  a;
    bit  keep;
    wr_t w;
    if (!frame_open) return;
    np = b.size() / 2;
    for (int k = 0; k < np; k++) begin
      keep = (k < int'(H)) && (y_m < int'(V));
`ifdef OV7670_DECIM2_EN
      keep = keep && (k % 2 == 0) && (y_m % 2 == 0);
      a = (y_m / 2) * int'(H / 2) + k / 2;
`else
      a = y_m * int'(H) + k;
`endif
      if (keep) begin
        w.data = {b[2*k], b[2*k+1]};
        w.addr = AW'(a);
        exp_q.push_back(w);
      end
    end
    if (complete) begin
      if (b.size() != 2 * H) exp_le++;
      y_m++;
    end
  endfunction

  function automatic byteq_t mk_bytes(input int n, input bit rnd);
    byteq_t q;
    q = {};
    for (int i = 0; i < n; i++) q.push_back(rnd ? 8'($urandom) : 8'(8'h10 + i));
    return q;
  endfunction

  task automatic vsync_pulse();
    @(negedge pclk);
    bus.href  = 1'b0;
    bus.vsync = 1'b1;
    if (frame_open) exp_fd++;
    repeat (3) @(negedge pclk);
    bus.vsync  = 1'b0;
    frame_open = 1'b1;
    y_m        = 0;
    repeat (2) @(negedge pclk);
  endtask

  // cut < 0: whole line; otherwise vsync rises after `cut` bytes.
  task automatic drive_line(input byteq_t b, input int cut);
    byteq_t s;
    int     n;
    n = (cut < 0) ? b.size() : cut;
    s = {};
    for (int i = 0; i < n; i++) s.push_back(b[i]);
    model_line(s, cut < 0);
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      bus.href = 1'b1;
      bus.din  = s[i];
    end
    if (cut < 0) begin
      @(negedge pclk);
      bus.href = 1'b0;
      bus.din  = 8'($urandom);
      repeat (2) @(negedge pclk);
    end else begin
      vsync_pulse();
    end
  endtask

  task automatic do_reset();
    @(negedge pclk);
    reset    = 1'b0;
    bus.href = 1'b0;
    @(posedge pclk);
    #1;
    check("rst_pix_we", 32'(bus.pix_we), 0);
    check("rst_pix_data", 32'(bus.pix_data), 0);
    check("rst_pix_addr", 32'(bus.pix_addr), 0);
    check("rst_frame_done", 32'(bus.frame_done), 0);
    check("rst_line_err", 32'(bus.line_err), 0);
    @(negedge pclk);
    reset      = 1'b1;
    frame_open = 1'b0;
    y_m        = 0;
  endtask

  task automatic settle(input string name);
    repeat (4) @(negedge pclk);
    check({name, "_frame_done"}, 32'(got_fd), 32'(exp_fd));
    check({name, "_line_err"}, 32'(got_le), 32'(exp_le));
    check({name, "_writes_left"}, 32'(exp_q.size()), 0);
  endtask

  task automatic mid_line_reset(input int m);
    byteq_t s;
    s = mk_bytes(m, 1'b1);
    model_line(s, 1'b0);
    for (int i = 0; i < m; i++) begin
      @(negedge pclk);
      bus.href = 1'b1;
      bus.din  = s[i];
    end
    do_reset();
  endtask

  task automatic random_frame();
    int nl, r, n;
    vsync_pulse();
    nl = $urandom_range(1, 3);
    for (int l = 0; l < nl; l++) begin
      r = $urandom_range(0, 11);
      if (r < 6)       n = 2 * H;
      else             n = $urandom_range(1, 2 * H + 4);
      if (r == 10)      drive_line(mk_bytes(2 * H, 1'b1), $urandom_range(1, 2 * H - 1));
      else if (r == 11) mid_line_reset($urandom_range(1, 2 * H));
      else              drive_line(mk_bytes(n, 1'b1), -1);
    end
  endtask

  initial begin
    bus.din   = 8'h00;
    bus.vsync = 1'b0;
    bus.href  = 1'b0;
    repeat (3) @(negedge pclk);
    check("init_pix_we", 32'(bus.pix_we), 0);
    check("init_pix_addr", 32'(bus.pix_addr), 0);
    check("init_frame_done", 32'(bus.frame_done), 0);
    reset = 1'b1;

    drive_line(mk_bytes(8, 1'b1), -1);
    settle("pre_vsync");

    vsync_pulse();
    drive_line(mk_bytes(8, 1'b0), -1);
    drive_line(mk_bytes(8, 1'b0), -1);
    vsync_pulse();
    settle("full_frame");

    drive_line(mk_bytes(6, 1'b1), -1);
    drive_line(mk_bytes(8, 1'b1), -1);
    vsync_pulse();
    settle("short_line");

    drive_line(mk_bytes(10, 1'b1), -1);
    drive_line(mk_bytes(8, 1'b1), -1);
    settle("long_line");

    vsync_pulse();
    drive_line(mk_bytes(8, 1'b1), 3);
    drive_line(mk_bytes(8, 1'b1), -1);
    settle("vsync_mid_line");

    mid_line_reset(5);
    drive_line(mk_bytes(8, 1'b1), -1);
    settle("reset_mid_line");

    for (int f = 0; f < 30; f++) random_frame();
    vsync_pulse();
    settle("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
